// File: rtl/frame_loader_rgb888.sv
// ----------------------------------------------------------------------------
// frame_loader_rgb888
//   Write-side feeder for the input frame BRAM read by the 3x3 window
//   generator. Accepts an RGB888 valid/ready stream framed by sof/eol, writes
//   one WIDTH x HEIGHT frame to sequential BRAM addresses starting at 0, and
//   pulses oStart once the last pixel has been written. Framing is checked on
//   every beat; a bad eol aborts the frame, a mid-frame sof resyncs to it.
//
// Ports
//   iClk     : clock, rising edge
//   iRst     : asynchronous active-high reset
//   iArm     : one-cycle pulse, arm for next frame (clears oDone/oErr)
//   iValid   : stream beat valid
//   iPixel   : stream pixel data
//   iSof     : beat is first pixel of a frame
//   iEol     : beat is last pixel of a line
//   oReady   : beats are accepted when iValid & oReady
//   oWrEn    : BRAM write enable (one cycle per accepted pixel)
//   oWrAddr  : BRAM write address (holds when oWrEn=0)
//   oWrData  : BRAM write data (holds when oWrEn=0)
//   oStart   : one-cycle pulse, frame complete (cycle after final write)
//   oBusy    : high while waiting for sof or loading
//   oDone    : high while a complete frame is held
//   oErr     : sticky framing error
// ----------------------------------------------------------------------------
module frame_loader_rgb888 #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 17,
   parameter int WIDTH  = 480,
   parameter int HEIGHT = 272,
   parameter int DEPTH  = WIDTH * HEIGHT
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iArm,
   input  logic              iValid,
   input  logic [DATA_W-1:0] iPixel,
   input  logic              iSof,
   input  logic              iEol,
   output logic              oReady,
   output logic              oWrEn,
   output logic [ADDR_W-1:0] oWrAddr,
   output logic [DATA_W-1:0] oWrData,
   output logic              oStart,
   output logic              oBusy,
   output logic              oDone,
   output logic              oErr
);

   localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SOF,
      LOAD,
      DONE
   } state_t;

   state_t              state_q,   state_d;
   logic [COL_W-1:0]    col_q,     col_d;
   logic [ROW_W-1:0]    row_q,     row_d;
   logic [ADDR_W-1:0]   addr_q,    addr_d;
   logic                wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                fin_q,     fin_d;
   logic                start_q,   start_d;
   logic                ready_q,   ready_d;
   logic                busy_q,    busy_d;
   logic                done_q,    done_d;
   logic                err_q,     err_d;

   logic                accept;
   logic                last_col;
   logic                last_row;

   assign accept   = iValid & ready_q;
   assign last_col = (col_q == COL_LAST);
   assign last_row = (row_q == ROW_LAST);

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      addr_d    = addr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      fin_d     = 1'b0;
      // fin_q marks the cycle of the final write; start follows one cycle later
      start_d   = fin_q;
      err_d     = err_q;

      case (state_q)
         IDLE: begin
            if (iArm) begin
               state_d = WAIT_SOF;
               col_d   = '0;
               row_d   = '0;
               addr_d  = '0;
               err_d   = 1'b0;
            end
         end

         WAIT_SOF: begin
            // iArm is ignored here; non-sof beats are consumed and dropped
            if (accept && iSof) begin
               wr_en_d   = 1'b1;
               wr_addr_d = '0;
               wr_data_d = iPixel;
               col_d     = COL_W'(1);
               row_d     = '0;
               addr_d    = ADDR_W'(1);
               state_d   = LOAD;
            end
         end

         LOAD: begin
            if (accept) begin
               if (iSof) begin
                  // addr is never 0 inside LOAD, so any sof here is mid-frame:
                  // treat it as the start of a new frame
                  err_d     = 1'b1;
                  wr_en_d   = 1'b1;
                  wr_addr_d = '0;
                  wr_data_d = iPixel;
                  col_d     = COL_W'(1);
                  row_d     = '0;
                  addr_d    = ADDR_W'(1);
               end else if (iEol != last_col) begin
                  err_d   = 1'b1;
                  col_d   = '0;
                  row_d   = '0;
                  addr_d  = '0;
                  state_d = WAIT_SOF;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = iPixel;
                  if (last_col) begin
                     col_d = '0;
                     if (last_row) begin
                        // final pixel: addr is not advanced so it never wraps
                        fin_d   = 1'b1;
                        state_d = DONE;
                     end else begin
                        row_d  = row_q + ROW_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                     end
                  end else begin
                     col_d  = col_q + COL_W'(1);
                     addr_d = addr_q + ADDR_W'(1);
                  end
               end
            end
         end

         DONE: begin
            if (iArm) begin
               state_d = WAIT_SOF;
               col_d   = '0;
               row_d   = '0;
               addr_d  = '0;
               err_d   = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // status outputs are registered from the next state
      ready_d = (state_d == WAIT_SOF) || (state_d == LOAD);
      busy_d  = ready_d;
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q   <= IDLE;
         col_q     <= '0;
         row_q     <= '0;
         addr_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         fin_q     <= 1'b0;
         start_q   <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         addr_q    <= addr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         fin_q     <= fin_d;
         start_q   <= start_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign oReady  = ready_q;
   assign oWrEn   = wr_en_q;
   assign oWrAddr = wr_addr_q;
   assign oWrData = wr_data_q;
   assign oStart  = start_q;
   assign oBusy   = busy_q;
   assign oDone   = done_q;
   assign oErr    = err_q;

endmodule

// File: tb/tb_frame_loader_rgb888.sv
// ----------------------------------------------------------------------------
// tb_frame_loader_rgb888
//   Directed bench for frame_loader_rgb888. A 4x3 instance covers framing,
//   gaps, error abort, sof resync and reset; a 480-wide instance covers a
//   long frame with full-width column counting.
// ----------------------------------------------------------------------------
module tb_frame_loader_rgb888;

   localparam int DW = 24;
   localparam int AW = 17;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int N  = W * H;
   localparam int WB = 480;
   localparam int HB = 32;
   localparam int NB = WB * HB;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, arm, valid, sof, eol;
   logic [DW-1:0] pixel;
   logic          ready, wr_en, start, busy, done, err;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   logic          arm_b, valid_b, sof_b, eol_b;
   logic [DW-1:0] pixel_b;
   logic          ready_b, wr_en_b, start_b, busy_b, done_b, err_b;
   logic [AW-1:0] wr_addr_b;
   logic [DW-1:0] wr_data_b;

   frame_loader_rgb888 #(.DATA_W(DW), .ADDR_W(AW), .WIDTH(W), .HEIGHT(H)) u_dut (
      .iClk(clk), .iRst(rst), .iArm(arm), .iValid(valid), .iPixel(pixel),
      .iSof(sof), .iEol(eol), .oReady(ready), .oWrEn(wr_en), .oWrAddr(wr_addr),
      .oWrData(wr_data), .oStart(start), .oBusy(busy), .oDone(done), .oErr(err)
   );

   frame_loader_rgb888 #(.DATA_W(DW), .ADDR_W(AW), .WIDTH(WB), .HEIGHT(HB)) u_dut_b (
      .iClk(clk), .iRst(rst), .iArm(arm_b), .iValid(valid_b), .iPixel(pixel_b),
      .iSof(sof_b), .iEol(eol_b), .oReady(ready_b), .oWrEn(wr_en_b),
      .oWrAddr(wr_addr_b), .oWrData(wr_data_b), .oStart(start_b),
      .oBusy(busy_b), .oDone(done_b), .oErr(err_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // write/start monitor for the small instance, sampled mid-cycle
   int            cyc = 0;
   logic [AW-1:0] log_addr[$];
   logic [DW-1:0] log_data[$];
   int            starts = 0, start_cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0;

   // monitor for the wide instance
   int            wr_cnt_b = 0, bad_b = 0, starts_b = 0, start_cyc_b = 0, last_cyc_b = 0;
   logic [AW-1:0] last_addr_b = '0;

   always @(negedge clk) begin
      cyc++;
      if (wr_en) begin
         if (log_addr.size() == 0) first_wr_cyc = cyc;
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
         last_wr_cyc = cyc;
      end
      if (start) begin
         starts++;
         start_cyc = cyc;
      end
      if (wr_en_b) begin
         if (wr_addr_b != AW'(wr_cnt_b)) bad_b++;
         if (wr_data_b != (DW'(wr_cnt_b) ^ 24'h5A0000)) bad_b++;
         wr_cnt_b++;
         last_addr_b = wr_addr_b;
         last_cyc_b  = cyc;
      end
      if (start_b) begin
         starts_b++;
         start_cyc_b = cyc;
      end
   end

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      starts = 0;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic arm_pulse();
      arm = 1'b1;
      step(1);
      arm = 1'b0;
   endtask

   // present one beat and hold it until accepted
   task automatic beat(input logic [DW-1:0] pix, input logic s, input logic e);
      logic ok;
      ok    = 1'b0;
      valid = 1'b1;
      pixel = pix;
      sof   = s;
      eol   = e;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         ok = ready;
         @(posedge clk);
         #1;
      end
      valid = 1'b0;
      sof   = 1'b0;
      eol   = 1'b0;
      check("beat_accepted", {31'd0, ok}, 32'd1);
   endtask

   // beats first_idx..N-1 of a frame, pixel = 100+index
   task automatic frame(input int first_idx, input int gap);
      for (int i = first_idx; i < N; i++) begin
         beat(DW'(100 + i), i == 0, (i % W) == W - 1);
         step(gap);
      end
   endtask

   task automatic check_writes(input int off, input int first_idx, input int n);
      for (int j = 0; j < n; j++) begin
         if (off + j < log_addr.size()) begin
            check("wr_addr", 32'(log_addr[off+j]), 32'(first_idx + j));
            check("wr_data", 32'(log_data[off+j]), 32'(100 + first_idx + j));
         end
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nr;
      rst = 1'b1; arm = 1'b0; valid = 1'b0; sof = 1'b0; eol = 1'b0; pixel = '0;
      arm_b = 1'b0; valid_b = 1'b0; sof_b = 1'b0; eol_b = 1'b0; pixel_b = '0;
      step(3);

      // reset state
      check("rst_ready", 32'(ready), 0);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_start", 32'(start), 0);
      check("rst_busy",  32'(busy),  0);
      check("rst_done",  32'(done),  0);
      check("rst_err",   32'(err),   0);
      check("rst_addr",  32'(wr_addr), 0);
      rst = 1'b0;
      step(2);

      // 1: contiguous frame
      arm_pulse();
      check("t1_busy",  32'(busy),  1);
      check("t1_ready", 32'(ready), 1);
      clear_log();
      frame(0, 0);
      step(4);
      check("t1_count", log_addr.size(), N);
      check_writes(0, 0, N);
      check("t1_starts", starts, 1);
      check("t1_start_lat", start_cyc - last_wr_cyc, 1);
      check("t1_contig", last_wr_cyc - first_wr_cyc, N - 1);
      check("t1_done",  32'(done),  1);
      check("t1_err",   32'(err),   0);
      check("t1_ready_done", 32'(ready), 0);
      check("t1_busy_done",  32'(busy),  0);

      // 2: gaps, two discarded pre-sof beats
      arm_pulse();
      check("t2_done_clr", 32'(done), 0);
      clear_log();
      beat(DW'(50), 1'b0, 1'b0);
      beat(DW'(51), 1'b0, 1'b0);
      frame(0, 1);
      step(4);
      check("t2_count", log_addr.size(), N);
      check_writes(0, 0, N);
      check("t2_starts", starts, 1);
      check("t2_done", 32'(done), 1);

      // 3: early eol at row 1 col 2 aborts, then a clean frame
      arm_pulse();
      clear_log();
      for (int i = 0; i < 6; i++) beat(DW'(100 + i), i == 0, (i % W) == W - 1);
      beat(DW'(106), 1'b0, 1'b1);
      step(2);
      check("t3_abort_count", log_addr.size(), 6);
      check("t3_err",   32'(err),   1);
      check("t3_busy",  32'(busy),  1);
      check("t3_ready", 32'(ready), 1);
      check("t3_done",  32'(done),  0);
      check("t3_starts_abort", starts, 0);
      clear_log();
      frame(0, 0);
      step(4);
      check("t3_count", log_addr.size(), N);
      check_writes(0, 0, N);
      check("t3_starts", starts, 1);
      check("t3_err_sticky", 32'(err), 1);
      check("t3_done", 32'(done), 1);
      arm_pulse();
      check("t3_err_clr", 32'(err), 0);

      // 4: sof at addr 6 resyncs
      clear_log();
      for (int i = 0; i < 6; i++) beat(DW'(100 + i), i == 0, (i % W) == W - 1);
      beat(DW'(200), 1'b1, 1'b0);
      check("t4_err", 32'(err), 1);
      frame(1, 0);
      step(4);
      check("t4_count", log_addr.size(), 18);
      check_writes(0, 0, 6);
      if (log_addr.size() > 6) begin
         check("t4_resync_addr", 32'(log_addr[6]), 0);
         check("t4_resync_data", 32'(log_data[6]), 200);
      end
      check_writes(7, 1, N - 1);
      check("t4_starts", starts, 1);
      check("t4_done", 32'(done), 1);

      // 5: reset during the write of addr 5
      arm_pulse();
      clear_log();
      for (int i = 0; i < 6; i++) beat(DW'(100 + i), i == 0, (i % W) == W - 1);
      check("t5_pre_wr_en", 32'(wr_en), 1);
      check("t5_pre_addr",  32'(wr_addr), 5);
      #2;
      rst = 1'b1;
      #1;
      check("t5_wr_en", 32'(wr_en), 0);
      check("t5_start", 32'(start), 0);
      check("t5_ready", 32'(ready), 0);
      check("t5_busy",  32'(busy),  0);
      step(2);
      rst = 1'b0;
      check("t5_logged", log_addr.size(), 5);
      clear_log();
      valid = 1'b1; sof = 1'b1; pixel = DW'(77);
      step(8);
      valid = 1'b0; sof = 1'b0;
      step(2);
      check("t5_no_writes", log_addr.size(), 0);
      check("t5_idle_busy",  32'(busy),  0);
      check("t5_idle_ready", 32'(ready), 0);
      check("t5_starts", starts, 0);

      // 6: wide frame on the 480-pixel instance, contiguous stream
      arm_b = 1'b1;
      step(1);
      arm_b = 1'b0;
      nr = 0;
      for (int i = 0; i < NB; i++) begin
         valid_b = 1'b1;
         pixel_b = DW'(i) ^ 24'h5A0000;
         sof_b   = (i == 0);
         eol_b   = (i % WB) == WB - 1;
         if (!ready_b) nr++;
         step(1);
      end
      valid_b = 1'b0; sof_b = 1'b0; eol_b = 1'b0;
      step(4);
      check("t6_not_ready", nr, 0);
      check("t6_count", wr_cnt_b, NB);
      check("t6_bad", bad_b, 0);
      check("t6_last_addr", 32'(last_addr_b), NB - 1);
      check("t6_starts", starts_b, 1);
      check("t6_start_lat", start_cyc_b - last_cyc_b, 1);
      check("t6_done", 32'(done_b), 1);
      check("t6_err",  32'(err_b),  0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
